// File: rtl/branch_predictor.sv
// branch_predictor: bimodal direction predictor built from a table of 2-bit
// saturating counters. It gives a one-cycle lookup response, trains from
// resolved branches, flags mispredictions and keeps saturating statistics.
// Optional build macro GSHARE_EN: the table index is XORed with a global
// history register, and the history snapshot is exported to fetch and
// returned on update.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_resp_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_pred,
`ifdef GSHARE_EN
    output logic [IDX_W-1:0] pred_ghr,
    input  logic [IDX_W-1:0] upd_ghr,
`endif
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int ENTRIES = 1 << IDX_W;

    // Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_MAX     = 2'b11;
    localparam logic [1:0] CTR_MIN     = 2'b00;

    logic [1:0]       ctr_tbl [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             miss_now;

    // The low two PC bits and everything above the index are ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    assign miss_now = upd_valid & (upd_taken ^ upd_pred);

    // Step a 2-bit counter toward the outcome, saturating at both ends.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != CTR_MAX) r = c + 2'd1;
        end else begin
            if (c != CTR_MIN) r = c - 2'd1;
        end
        return r;
    endfunction

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Hash the PC with the global history for both lookup and training.
    always_comb begin
        pred_idx = pred_pc[IDX_W+1:2] ^ ghr;
        upd_idx  = upd_pc[IDX_W+1:2] ^ upd_ghr;
    end

    // History shift on every resolved branch; repair from the carried
    // snapshot when the branch mispredicted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (miss_now) begin
            ghr <= {upd_ghr[IDX_W-2:0], upd_taken};
        end else if (upd_valid) begin
            ghr <= {ghr[IDX_W-2:0], upd_taken};
        end
    end

    // Snapshot of the history used by each lookup, aligned with the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_ghr <= '0;
        end else if (pred_valid) begin
            pred_ghr <= ghr;
        end
    end
`else
    // Pure bimodal indexing from the word-aligned PC.
    always_comb begin
        pred_idx = pred_pc[IDX_W+1:2];
        upd_idx  = upd_pc[IDX_W+1:2];
    end
`endif

    // Counter table: training from execute.
    // NOTE: the table is reset entry by entry because weakly-not-taken after
    // reset is visible behaviour; a reset-less RAM would predict garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_tbl[i] <= CTR_WEAK_NT;
            end
        end else if (upd_valid) begin
            ctr_tbl[upd_idx] <= sat_step(ctr_tbl[upd_idx], upd_taken);
        end
    end

    // Lookup response; reads the pre-update table value when a same-index
    // update lands in the same cycle.
    // NOTE: non-blocking assignments here are what guarantee the lookup sees
    // the old counter value even though the table write shares the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
        end else begin
            pred_resp_valid <= pred_valid;
            if (pred_valid) begin
                pred_taken <= ctr_tbl[pred_idx][1];
            end
        end
    end

    // Registered misprediction pulse and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict <= 1'b0;
            br_count   <= '0;
            miss_count <= '0;
        end else begin
            mispredict <= miss_now;
            if (upd_valid && (br_count != '1)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (miss_now && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (default bimodal build).
// A second instance with 2-bit statistics counters shares the stimulus so
// that counter saturation is observed within a short run.
module tb_branch_predictor;

    localparam int XLEN  = 32;
    localparam int IDX_W = 6;

    logic            clk;
    logic            rst_n;
    logic            pred_valid;
    logic [XLEN-1:0] pred_pc;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_pred;

    logic        pred_resp_valid, pred_taken, mispredict;
    logic [31:0] br_count, miss_count;
    logic        s_resp_valid, s_taken, s_mispredict;
    logic [1:0]  s_br_count, s_miss_count;

`ifdef GSHARE_EN
    logic [IDX_W-1:0] pred_ghr, s_pred_ghr;
    logic [IDX_W-1:0] upd_ghr;
    initial upd_ghr = '0;
`endif

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_W(IDX_W), .XLEN(XLEN), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
`ifdef GSHARE_EN
        .pred_ghr(pred_ghr), .upd_ghr(upd_ghr),
`endif
        .mispredict(mispredict), .br_count(br_count), .miss_count(miss_count)
    );

    branch_predictor #(.IDX_W(IDX_W), .XLEN(XLEN), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_resp_valid(s_resp_valid), .pred_taken(s_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_pred(upd_pred),
`ifdef GSHARE_EN
        .pred_ghr(s_pred_ghr), .upd_ghr(upd_ghr),
`endif
        .mispredict(s_mispredict), .br_count(s_br_count), .miss_count(s_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        up;
        logic        e_resp;
        logic        e_taken;
        logic        e_mis;
        int          e_br;
        int          e_miss;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic pv, input logic [31:0] ppc,
                                input logic uv, input logic [31:0] upc,
                                input logic ut, input logic up,
                                input logic e_resp, input logic e_taken,
                                input logic e_mis, input int e_br, input int e_miss);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.uv = uv; v.upc = upc; v.ut = ut; v.up = up;
        v.e_resp = e_resp; v.e_taken = e_taken; v.e_mis = e_mis;
        v.e_br = e_br; v.e_miss = e_miss;
        return v;
    endfunction

    function automatic logic [31:0] sat3(input int v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] ppc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic up);
        pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    endtask

    task automatic check_all(input string tag, input logic e_resp, input logic e_taken,
                             input logic e_mis, input int e_br, input int e_miss);
        check({tag, " resp_valid"}, 32'(pred_resp_valid), 32'(e_resp));
        check({tag, " pred_taken"}, 32'(pred_taken), 32'(e_taken));
        check({tag, " mispredict"}, 32'(mispredict), 32'(e_mis));
        check({tag, " br_count"}, br_count, 32'(e_br));
        check({tag, " miss_count"}, miss_count, 32'(e_miss));
        check({tag, " small br_count"}, 32'(s_br_count), sat3(e_br));
        check({tag, " small miss_count"}, 32'(s_miss_count), sat3(e_miss));
    endtask

    initial begin
        //                pv  ppc      uv  upc      ut  up    resp tk  mis br  miss
        vecs[0]  = mk(1, 32'h40,  0, 32'h0,   0, 0,   1, 0, 0, 0,  0); // reset lookup -> 01
        vecs[1]  = mk(0, 32'h0,   1, 32'h40,  1, 0,   0, 0, 1, 1,  1); // 01 -> 10
        vecs[2]  = mk(0, 32'h0,   1, 32'h40,  1, 0,   0, 0, 1, 2,  2); // 10 -> 11
        vecs[3]  = mk(1, 32'h40,  0, 32'h0,   0, 0,   1, 1, 0, 2,  2);
        vecs[4]  = mk(0, 32'h0,   0, 32'h0,   0, 0,   0, 1, 0, 2,  2); // taken holds
        vecs[5]  = mk(0, 32'h0,   1, 32'h40,  1, 1,   0, 1, 0, 3,  2); // stays 11
        vecs[6]  = mk(0, 32'h0,   1, 32'h40,  1, 1,   0, 1, 0, 4,  2);
        vecs[7]  = mk(0, 32'h0,   1, 32'h40,  1, 1,   0, 1, 0, 5,  2);
        vecs[8]  = mk(1, 32'h40,  1, 32'h40,  0, 1,   1, 1, 1, 6,  3); // old 11; -> 10
        vecs[9]  = mk(1, 32'h40,  0, 32'h0,   0, 0,   1, 1, 0, 6,  3); // 10 taken
        vecs[10] = mk(0, 32'h0,   1, 32'h40,  0, 1,   0, 1, 1, 7,  4); // -> 01
        vecs[11] = mk(1, 32'h40,  0, 32'h0,   0, 0,   1, 0, 0, 7,  4);
        vecs[12] = mk(1, 32'h80,  1, 32'h80,  1, 0,   1, 0, 1, 8,  5); // no bypass
        vecs[13] = mk(1, 32'h80,  0, 32'h0,   0, 0,   1, 1, 0, 8,  5); // now 10
        vecs[14] = mk(0, 32'h0,   1, 32'h0,   1, 0,   0, 1, 1, 9,  6); // idx0 -> 10
        vecs[15] = mk(0, 32'h0,   1, 32'h0,   1, 1,   0, 1, 0, 10, 6); // idx0 -> 11
        vecs[16] = mk(1, 32'h100, 0, 32'h0,   0, 0,   1, 1, 0, 10, 6); // alias idx0
        vecs[17] = mk(1, 32'h4,   0, 32'h0,   0, 0,   1, 0, 0, 10, 6); // idx1 untouched
        vecs[18] = mk(1, 32'h103, 0, 32'h0,   0, 0,   1, 1, 0, 10, 6); // pc[1:0] ignored
        vecs[19] = mk(0, 32'h0,   0, 32'h0,   1, 0,   0, 1, 0, 10, 6); // no upd_valid
        vecs[20] = mk(1, 32'h40,  1, 32'h80,  0, 1,   1, 0, 1, 11, 7); // diff idx
        vecs[21] = mk(1, 32'h80,  0, 32'h0,   0, 0,   1, 0, 0, 11, 7); // 0x80 now 01

        rst_n = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0, 0);
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].pv, vecs[i].ppc, vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].up);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_resp, vecs[i].e_taken,
                      vecs[i].e_mis, vecs[i].e_br, vecs[i].e_miss);
        end

        // In-flight lookup and update, then asynchronous reset between edges.
        drive(1, 32'h0, 1, 32'h0, 1, 0);
        @(posedge clk);
        #1;
        check_all("pre_reset", 1, 1, 1, 12, 8);
        drive(0, 32'h0, 0, 32'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // The trained entry must be back at weakly-not-taken.
        drive(1, 32'h0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_reset idx0", 1, 0, 0, 0, 0);
        drive(1, 32'h40, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_reset idx16", 1, 0, 0, 0, 0);
        drive(0, 32'h0, 0, 32'h0, 0, 0);
        @(posedge clk);
        #1;
        check_all("post_reset idle", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch direction predictor for the RISC-V core.
- Fetch queries it with the branch PC and gets a taken/not-taken guess one cycle later.
- Execute returns the resolved outcome from the branch-condition logic (func3 plus ALU flags). That outcome trains a table of 2-bit saturating counters.
- The block also flags mispredictions and keeps branch and mispredict statistics.

Parameters:
- IDX_W, 6, log2 of table entries (64 entries); index = pc[IDX_W+1:2].
- XLEN, 32, PC width.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  Clock, rising edge.
- rst_n  in  1  Asynchronous reset, active-low.
- pred_valid  in  1  Fetch lookup request this cycle.
- pred_pc  in  XLEN  PC of the instruction being looked up.
- pred_resp_valid  out  1  Registered; pred_valid delayed one cycle.
- pred_taken  out  1  Registered; MSB of the indexed counter, sampled at request.
- upd_valid  in  1  Resolved conditional branch from execute this cycle.
- upd_pc  in  XLEN  PC of the resolved branch.
- upd_taken  in  1  Actual outcome (branch-unit out).
- upd_pred  in  1  Prediction used for this branch, carried down the pipe.
- mispredict  out  1  Registered 1-cycle pulse when upd_taken != upd_pred.
- br_count  out  CNT_W  Resolved branches since reset.
- miss_count  out  CNT_W  Mispredictions since reset.

Behaviour:
- Reset (rst_n=0, async): every counter = 2'b01 (weakly not-taken); pred_resp_valid=0, pred_taken=0, mispredict=0, br_count=0, miss_count=0. This is the same on reset mid-operation; in-flight requests are dropped.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Predict taken = bit[1].
- Lookup latency is 1 cycle. pred_valid at edge N gives pred_resp_valid=1 and pred_taken after edge N. Back-to-back requests give one response per cycle.
- With pred_valid=0: pred_resp_valid=0 and pred_taken holds its last value.
- Update on upd_valid at edge N:
  - counter[idx(upd_pc)] increments on taken, saturating at 11.
  - It decrements on not-taken, saturating at 00.
- Simultaneous lookup and update, same index: the lookup returns the pre-update value (no bypass). The update is still applied.
- Simultaneous lookup and update, different indices: the two are independent.
- Aliasing: PCs differing only outside pc[IDX_W+1:2] share an entry. No tags.
- mispredict = upd_valid & (upd_taken ^ upd_pred), registered. It is 0 in any cycle after upd_valid=0.
- br_count increments on each upd_valid.
- miss_count increments on each mispredicting update.
- Both statistics counters saturate at all-ones; no wrap.
- pc[1:0] and bits above IDX_W+1 are ignored.

Optional Feature:
- Macro GSHARE_EN.
- When defined:
  - Add a global history register ghr[IDX_W-1:0], reset to 0.
  - Add output pred_ghr (IDX_W): a registered snapshot of ghr at request, aligned with pred_resp_valid.
  - Add input upd_ghr (IDX_W): the snapshot carried with the branch.
  - Lookup index = pc[IDX_W+1:2] ^ ghr.
  - Update index = upd_pc[IDX_W+1:2] ^ upd_ghr.
  - On upd_valid, ghr <= {ghr[IDX_W-2:0], upd_taken}.
  - On mispredict, ghr <= {upd_ghr[IDX_W-2:0], upd_taken} (history repair).
- When undefined: no ghr, no extra ports, pure bimodal indexing as above.

Test Plan:
- Reset, then pred_valid with pred_pc=0x40: next cycle pred_resp_valid=1, pred_taken=0; br_count=0, miss_count=0.
- Two updates to 0x40 with upd_taken=1, upd_pred=0, then lookup 0x40:
  - counter goes 01→10→11; pred_taken=1.
  - mispredict pulses on each update; miss_count=2, br_count=2.
- Saturation on 0x40:
  - Three more taken updates: counter stays 11.
  - One not-taken update: counter 10, lookup still taken.
  - A second not-taken update: counter 01, lookup not-taken.
- Same cycle: lookup 0x80 plus update 0x80 taken from reset → pred_taken=0 (old 01). The following lookup gives 1 (10).
- Alias: update 0x0 taken twice, then lookup 0x100 (IDX_W=6) → pred_taken=1. A lookup of 0x4 stays 0.
- Assert rst_n low mid-stream after training: all outputs 0 immediately. After release, a lookup of the trained PC returns not-taken, and the counters read 0.
